sram_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SRAM-like request/response bus. It sits directly downstream of the CPU core. It merges the core's instruction-fetch and data-access channels onto a single memory port and routes each response back to the master that issued it. Only one transaction is outstanding at a time. Data requests have priority, and a starvation counter guarantees instruction fetch progress.

---
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like bus.
// One transaction in flight; data has priority, bounded by a starvation counter.
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        lat;
    logic        owner;
    logic [31:0] rdata_r;
    logic [3:0]  starve_cnt;
    logic        starve_hit;
    logic        grant_inst, grant_data;

    // Inst only beats a competing data request once it has been passed over enough times.
    assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
    assign grant_inst = (state == IDLE) && inst_req && (!data_req || starve_hit);
    assign grant_data = (state == IDLE) && data_req && !grant_inst;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_inst || grant_data) state_nxt = REQ;
            REQ:     if (mem_addr_ok)              state_nxt = WAIT;
            WAIT:    if (mem_data_ok)              state_nxt = RESP;
            RESP:                                  state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lat        <= '0;
            rdata_r    <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant_inst) begin
                owner      <= 1'b0;
                lat        <= '{inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
                starve_cnt <= '0;
            end else if (grant_data) begin
                owner <= 1'b1;
                lat   <= '{data_wr, data_size, data_addr, data_wstrb, data_wdata};
                if (inst_req && !starve_hit)
                    starve_cnt <= starve_cnt + 4'd1;
            end
            if (state == WAIT && mem_data_ok)
                rdata_r <= mem_rdata;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = (state == RESP) && !owner;
    assign data_data_ok = (state == RESP) && owner;
    assign inst_rdata   = rdata_r;
    assign data_rdata   = rdata_r;

    assign mem_req   = (state == REQ);
    assign mem_wr    = lat.wr;
    assign mem_size  = lat.size;
    assign mem_addr  = lat.addr;
    assign mem_wstrb = lat.wstrb;
    assign mem_wdata = lat.wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: master driver with arbitration model,
// memory responder, and a response monitor sharing expectation queues.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int LIM   = 4;
    localparam int NCYC  = 4000;
    localparam int DRAIN = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        owner;
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [3:0]  wstrb;
        bit [31:0] wdata;
    } mreq_t;

    typedef struct {
        bit        owner;
        bit        wr;
        bit [31:0] rdata;
        int        due;
    } resp_t;

    mreq_t mem_q[$];
    resp_t resp_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0;
    bit    busy = 0, abort = 0, waiting = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_size", mem_size, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
    endtask

    function automatic mreq_t rand_req(input bit own);
        mreq_t r;
        r.owner = own;
        r.wr    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        r.wstrb = 4'($urandom_range(0, 15));
        r.wdata = $urandom;
        return r;
    endfunction

    // Master driver and arbitration reference model.
    initial begin
        bit    ip = 0, dp = 0, post_reset = 0, do_chk, exp_i, exp_d;
        int    starve = 0, nresets = 0;
        mreq_t ir, dr;
        ir = rand_req(0);
        dr = rand_req(1);
        reset = 1;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1 chk_reset();
        for (int c = 0; c < NCYC + DRAIN; c++) begin
            @(negedge clk);
            reset  = 0;
            abort  = 0;
            do_chk = post_reset;
            post_reset = 0;
            if (c < NCYC && c > 100 && waiting && nresets < 4 && $urandom_range(0, 15) == 0) begin
                // abort a transaction sitting in WAIT
                reset = 1;
                abort = 1;
                mem_q.delete();
                resp_q.delete();
                busy = 0;
                starve = 0;
                nresets++;
                post_reset = 1;
                continue;
            end
            if (c < NCYC) begin
                if (!ip && $urandom_range(0, 7) < 2) begin ip = 1; ir = rand_req(0); end
                if (!dp && $urandom_range(0, 7) < 2) begin dp = 1; dr = rand_req(1); end
            end
            inst_req = ip; inst_wr = ir.wr; inst_size = ir.size; inst_addr = ir.addr;
            inst_wstrb = ir.wstrb; inst_wdata = ir.wdata;
            data_req = dp; data_wr = dr.wr; data_size = dr.size; data_addr = dr.addr;
            data_wstrb = dr.wstrb; data_wdata = dr.wdata;
            #1;
            if (do_chk) chk_reset();
            exp_i = !busy && ip && (!dp || starve == LIM);
            exp_d = !busy && dp && !exp_i;
            chk("inst_addr_ok", inst_addr_ok, exp_i);
            chk("data_addr_ok", data_addr_ok, exp_d);
            if (exp_i) begin
                mem_q.push_back(ir);
                ip = 0; busy = 1; starve = 0;
            end else if (exp_d) begin
                mem_q.push_back(dr);
                if (ip && starve < LIM) starve++;
                dp = 0; busy = 1;
            end
        end
        chk("drain_idle", {busy, ip, dp}, 3'b000);
        chk("drain_queues", mem_q.size() + resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Memory responder: random stalls, random latency, spurious handshakes.
    initial begin
        mreq_t cur;
        int    dly = 0;
        bit    kick = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        cur = rand_req(0);
        forever begin
            @(negedge clk);
            #1;
            mem_rdata = $urandom;
            if (abort) begin
                waiting = 0;
                mem_addr_ok = 0;
                mem_data_ok = 1;
                kick = 1;
            end else if (waiting) begin
                chk("mem_req_in_wait", mem_req, 0);
                mem_addr_ok = 1'($urandom_range(0, 1));
                if (dly == 0) begin
                    mem_data_ok = 1;
                    resp_q.push_back('{cur.owner, cur.wr, mem_rdata, cyc + 1});
                    waiting = 0;
                end else begin
                    dly--;
                    mem_data_ok = 0;
                end
            end else if (mem_req) begin
                mem_data_ok = ($urandom_range(0, 3) == 0);
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", mem_req, 0);
                    mem_addr_ok = 0;
                end else begin
                    chk("mem_wr", mem_wr, mem_q[0].wr);
                    chk("mem_size", mem_size, mem_q[0].size);
                    chk("mem_addr", mem_addr, mem_q[0].addr);
                    chk("mem_wstrb", mem_wstrb, mem_q[0].wstrb);
                    chk("mem_wdata", mem_wdata, mem_q[0].wdata);
                    mem_addr_ok = ($urandom_range(0, 2) != 0);
                    if (mem_addr_ok) begin
                        cur = mem_q.pop_front();
                        waiting = 1;
                        dly = $urandom_range(0, 5);
                    end
                end
            end else begin
                mem_addr_ok = 1'($urandom_range(0, 1));
                mem_data_ok = kick ? 1'b1 : ($urandom_range(0, 3) == 0);
                kick = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a master sees data_ok.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (resp_q.size() > 0 && resp_q[0].due < cyc) begin
                chk("missing_data_ok", 0, 1);
                void'(resp_q.pop_front());
                busy = 0;
            end
            if (inst_data_ok || data_data_ok) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_cycle", cyc, r.due);
                    chk("inst_data_ok", inst_data_ok, !r.owner);
                    chk("data_data_ok", data_data_ok, r.owner);
                    if (!r.wr)
                        chk("rdata", r.owner ? data_rdata : inst_rdata, r.rdata);
                end
                busy = 0;
            end
        end
    end

endmodule
